// File: rtl/hilo_md_if.sv
// Dispatch-to-mul/div bundle: two request slots toward the scheduler; grant, busy and the HI/LO write back.
// The dispatch side drives master and the scheduler takes slave; clk/rst_/flush travel as plain ports.
interface hilo_md_if;
  logic        req0_valid;
  logic [1:0]  req0_op;
  logic [31:0] req0_a;
  logic [31:0] req0_b;
  logic        req1_valid;
  logic [1:0]  req1_op;
  logic [31:0] req1_a;
  logic [31:0] req1_b;
  logic [1:0]  grant;
  logic        md_busy;
  logic        hilo_we;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    input  grant, md_busy, hilo_we, hi_out, lo_out
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    output grant, md_busy, hilo_we, hi_out, lo_out
  );
endinterface

// File: rtl/hilo_md_scheduler.sv
// Shared MULT/MULTU/DIV/DIVU sequencer: slot 0 wins arbitration, the loser is not held; hilo_we after MUL_LAT+1 / DIV_ITER+1 cycles.
// md_busy stalls dispatch until the op retires; define MD_EARLY_OUT_EN to let divides with |a|<|b| finish in one cycle.
module hilo_md_scheduler #(
  parameter int MUL_LAT  = 2,
  parameter int DIV_ITER = 32
) (
  input logic      clk,
  input logic      rst_,
  input logic      flush,
  hilo_md_if.slave md
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  op_q;
  logic [31:0] a_q, b_q;
  logic [31:0] quo_q, rem_q, dvs_q;
  logic [31:0] hi_q, lo_q;
  logic        we_q, busy_q;

  logic [1:0]  grant_c;
  logic [1:0]  sel_op;
  logic [31:0] sel_a, sel_b, mag_a, mag_b;
  logic        early;

  logic [32:0] rem_sh, diff;
  logic        take;
  logic [31:0] rem_nx, quo_nx;
  logic [63:0] prod;
  logic [31:0] div_hi, div_lo, res_hi, res_lo;
  logic        div_sgn;

  // Reset also blocks grant so a request seen during reset is never started.
  always_comb begin
    grant_c = 2'b00;
    if (state_q == IDLE && !flush && rst_) begin
      if (md.req0_valid)      grant_c = 2'b01;
      else if (md.req1_valid) grant_c = 2'b10;
    end
  end

  always_comb begin
    sel_op = grant_c[1] ? md.req1_op : md.req0_op;
    sel_a  = grant_c[1] ? md.req1_a  : md.req0_a;
    sel_b  = grant_c[1] ? md.req1_b  : md.req0_b;
    mag_a  = (sel_op == 2'b10 && sel_a[31]) ? (~sel_a + 32'd1) : sel_a;
    mag_b  = (sel_op == 2'b10 && sel_b[31]) ? (~sel_b + 32'd1) : sel_b;
`ifdef MD_EARLY_OUT_EN
    early  = sel_op[1] && (sel_b != 32'd0) && (mag_a < mag_b);
`else
    early  = 1'b0;
`endif
  end

  // One restoring step: quo_q shifts the dividend out while the quotient bits shift in.
  always_comb begin
    rem_sh = {rem_q, quo_q[31]};
    diff   = rem_sh - {1'b0, dvs_q};
    take   = !diff[32];
    rem_nx = take ? diff[31:0] : rem_sh[31:0];
    quo_nx = {quo_q[30:0], take};
  end

  always_comb begin
    if (op_q[0]) prod = {32'd0, a_q} * {32'd0, b_q};
    else         prod = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};

    div_sgn = !op_q[0];
    if (b_q == 32'd0) begin
      div_lo = 32'hFFFF_FFFF;
      div_hi = a_q;
    end else begin
      div_lo = (div_sgn && (a_q[31] ^ b_q[31])) ? (~quo_nx + 32'd1) : quo_nx;
      div_hi = (div_sgn && a_q[31]) ? (~rem_nx + 32'd1) : rem_nx;
    end

    // The IDLE path is the early-out divide: quotient 0, remainder is the dividend itself.
    unique case (state_q)
      IDLE: begin
        res_hi = sel_a;
        res_lo = 32'd0;
      end
      DIV: begin
        res_hi = div_hi;
        res_lo = div_lo;
      end
      default: begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (grant_c != 2'b00) begin
          if (sel_op[1]) begin
            state_d = early ? DONE : DIV;
            cnt_d   = 6'(DIV_ITER - 1);
          end else begin
            state_d = MUL;
            cnt_d   = 6'(MUL_LAT - 1);
          end
        end
      end
      MUL, DIV: begin
        if (cnt_q == 6'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 6'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
      dvs_q   <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= (state_d == DONE);
      busy_q  <= (state_d != IDLE);
      if (state_d == DONE) begin
        hi_q <= res_hi;
        lo_q <= res_lo;
      end
      if (grant_c != 2'b00) begin
        op_q  <= sel_op;
        a_q   <= sel_a;
        b_q   <= sel_b;
        quo_q <= mag_a;
        rem_q <= 32'd0;
        dvs_q <= mag_b;
      end else if (state_q == DIV) begin
        quo_q <= quo_nx;
        rem_q <= rem_nx;
      end
    end
  end

  assign md.grant   = grant_c;
  assign md.md_busy = busy_q;
  assign md.hilo_we = we_q;
  assign md.hi_out  = hi_q;
  assign md.lo_out  = lo_q;

endmodule

// File: tb/tb_hilo_md_scheduler.sv
// Bench for hilo_md_scheduler: directed cases plus random ops against an arithmetic reference model.
// Honors MD_EARLY_OUT_EN when predicting divide latency.
module tb_hilo_md_scheduler;
  localparam int MUL_LAT = 2;

  logic clk   = 1'b0;
  logic rst_  = 1'b0;
  logic flush = 1'b0;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] last_hi = 32'd0;
  logic [31:0] last_lo = 32'd0;

  hilo_md_if md_if();

  hilo_md_scheduler #(.MUL_LAT(MUL_LAT), .DIV_ITER(32)) dut (
    .clk  (clk),
    .rst_ (rst_),
    .flush(flush),
    .md   (md_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {HI, LO} straight from the arithmetic definition of each op.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = 64'd0;
    case (op)
      2'd0: r = sa * sb;
      2'd1: r = ua * ub;
      2'd2: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          r  = {sr[31:0], sq[31:0]};
        end
      end
      default: begin
        if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
        else begin
          uq = ua / ub;
          ur = ua % ub;
          r  = {ur[31:0], uq[31:0]};
        end
      end
    endcase
    return r;
  endfunction

  function automatic int exp_lat(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MD_EARLY_OUT_EN
    longint ma, mb;
`endif
    if (!op[1]) return MUL_LAT + 1;
`ifdef MD_EARLY_OUT_EN
    ma = op[0] ? longint'({32'd0, a}) : longint'($signed(a));
    mb = op[0] ? longint'({32'd0, b}) : longint'($signed(b));
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (b != 32'd0 && ma < mb) return 1;
`endif
    return 33;
  endfunction

  task automatic present(input int slot, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (slot == 0) begin
      md_if.req0_valid = 1'b1; md_if.req0_op = op; md_if.req0_a = a; md_if.req0_b = b;
    end else begin
      md_if.req1_valid = 1'b1; md_if.req1_op = op; md_if.req1_a = a; md_if.req1_b = b;
    end
  endtask

  // Called at the negedge where the request is presented; returns one cycle after DONE.
  task automatic complete(input string tag, input int slot, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int          lat;
    exp = model(op, a, b);
    #1;
    chk({tag, "_grant"}, {62'd0, md_if.grant}, (slot == 0) ? 64'd1 : 64'd2);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      md_if.req0_valid = 1'b0;
      md_if.req1_valid = 1'b0;
      #1;
      if (k == 1) chk({tag, "_busy_first"}, {63'd0, md_if.md_busy}, 64'd1);
      if (md_if.hilo_we) begin
        chk({tag, "_busy_done"}, {63'd0, md_if.md_busy}, 64'd1);
        lat = k;
        break;
      end
    end
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat(op, a, b)));
    chk({tag, "_hi"}, {32'd0, md_if.hi_out}, {32'd0, exp[63:32]});
    chk({tag, "_lo"}, {32'd0, md_if.lo_out}, {32'd0, exp[31:0]});
    last_hi = exp[63:32];
    last_lo = exp[31:0];
    @(negedge clk);
    #1;
    chk({tag, "_we_pulse"}, {63'd0, md_if.hilo_we}, 64'd0);
    chk({tag, "_idle"}, {63'd0, md_if.md_busy}, 64'd0);
  endtask

  task automatic run(input string tag, input int slot, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    present(slot, op, a, b);
    complete(tag, slot, op, a, b);
  endtask

  initial begin
    int we_seen;
    md_if.req0_valid = 1'b0; md_if.req0_op = 2'd0; md_if.req0_a = 32'd0; md_if.req0_b = 32'd0;
    md_if.req1_valid = 1'b0; md_if.req1_op = 2'd0; md_if.req1_a = 32'd0; md_if.req1_b = 32'd0;

    // Reset with a request pending: nothing may be granted or started.
    rst_ = 1'b0;
    present(0, 2'd0, 32'd1, 32'd1);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", {62'd0, md_if.grant}, 64'd0);
    chk("rst_busy", {63'd0, md_if.md_busy}, 64'd0);
    chk("rst_we", {63'd0, md_if.hilo_we}, 64'd0);
    chk("rst_hi", {32'd0, md_if.hi_out}, 64'd0);
    chk("rst_lo", {32'd0, md_if.lo_out}, 64'd0);
    md_if.req0_valid = 1'b0;
    rst_ = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_busy", {63'd0, md_if.md_busy}, 64'd0);
    @(negedge clk);

    run("mult_neg", 0, 2'd0, 32'hFFFF_FFFE, 32'd3);
    chk("mult_neg_hi_const", {32'd0, md_if.hi_out}, 64'hFFFF_FFFF);
    chk("mult_neg_lo_const", {32'd0, md_if.lo_out}, 64'hFFFF_FFFA);
    run("div_m7_2", 0, 2'd2, 32'hFFFF_FFF9, 32'd2);
    chk("div_m7_2_lo_const", {32'd0, md_if.lo_out}, 64'hFFFF_FFFD);
    chk("div_m7_2_hi_const", {32'd0, md_if.hi_out}, 64'hFFFF_FFFF);
    run("divu_by0", 1, 2'd3, 32'd7, 32'd0);
    chk("divu_by0_lo_const", {32'd0, md_if.lo_out}, 64'hFFFF_FFFF);
    chk("divu_by0_hi_const", {32'd0, md_if.hi_out}, 64'd7);
    run("div_by0_neg", 0, 2'd2, 32'hFFFF_FFF9, 32'd0);
    run("div_ovf", 0, 2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf_lo_const", {32'd0, md_if.lo_out}, 64'h8000_0000);
    chk("div_ovf_hi_const", {32'd0, md_if.hi_out}, 64'd0);
    run("divu_5_9", 1, 2'd3, 32'd5, 32'd9);
    chk("divu_5_9_hi_const", {32'd0, md_if.hi_out}, 64'd5);
    run("div_m5_9", 0, 2'd2, 32'hFFFF_FFFB, 32'd9);
    run("multu_max", 1, 2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Both slots at once: slot 0 first, then slot 1 re-presented.
    present(1, 2'd3, 32'd100, 32'd7);
    run("arb_slot0", 0, 2'd1, 32'h0001_0000, 32'h0003_0000);
    run("arb_slot1", 1, 2'd3, 32'd100, 32'd7);

    // Flush ten cycles into a divide, then flush racing a fresh request.
    present(0, 2'd2, 32'h1234_5678, 32'd3);
    #1;
    chk("fl_grant", {62'd0, md_if.grant}, 64'd1);
    @(negedge clk);
    md_if.req0_valid = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    #1;
    chk("fl_busy", {63'd0, md_if.md_busy}, 64'd0);
    chk("fl_we", {63'd0, md_if.hilo_we}, 64'd0);
    chk("fl_hi_hold", {32'd0, md_if.hi_out}, {32'd0, last_hi});
    chk("fl_lo_hold", {32'd0, md_if.lo_out}, {32'd0, last_lo});
    md_if.req0_valid = 1'b1;
    #1;
    chk("fl_beats_req", {62'd0, md_if.grant}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    md_if.req0_valid = 1'b0;
    #1;
    chk("fl_busy_after", {63'd0, md_if.md_busy}, 64'd0);
    we_seen = 0;
    repeat (35) begin
      @(negedge clk);
      #1;
      if (md_if.hilo_we) we_seen++;
    end
    chk("fl_no_write", 64'(we_seen), 64'd0);

    // Reset in the middle of a multiply.
    @(negedge clk);
    present(0, 2'd0, 32'd3, 32'd5);
    #1;
    chk("rm_grant", {62'd0, md_if.grant}, 64'd1);
    @(negedge clk);
    md_if.req0_valid = 1'b0;
    rst_ = 1'b0;
    #1;
    chk("rm_busy_pre", {63'd0, md_if.md_busy}, 64'd1);
    @(negedge clk);
    #1;
    chk("rm_busy", {63'd0, md_if.md_busy}, 64'd0);
    chk("rm_we", {63'd0, md_if.hilo_we}, 64'd0);
    chk("rm_hi", {32'd0, md_if.hi_out}, 64'd0);
    chk("rm_lo", {32'd0, md_if.lo_out}, 64'd0);
    present(0, 2'd1, 32'd9, 32'd9);
    #1;
    chk("rm_req_in_rst", {62'd0, md_if.grant}, 64'd0);
    @(negedge clk);
    md_if.req0_valid = 1'b0;
    rst_ = 1'b1;
    #1;
    chk("rm_not_started", {63'd0, md_if.md_busy}, 64'd0);
    @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      int          slot;
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       a = 32'($urandom_range(0, 20));
        1:       a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 40));
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      slot = int'($urandom_range(0, 1));
      run($sformatf("rnd%0d", i), slot, op, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
